// File: rtl/pipe_register_pkg.sv
// Shared types and sizing helpers for the pipe_register pipeline.
package pipe_register_pkg;

    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_DEPTH = 2;

    typedef logic [127:0] aes_state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// One valid/ready register slice; PIPE_REGISTER_ZERO_IDLE_EN zeroes data whenever the slice empties.
module pipe_reg_slice
    import pipe_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             rdy,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic load;

    assign load = !v || rdy;

    // NOTE: data is reset as well as valid, so out_data reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every slice sampling pre-edge neighbour state.
            v <= 1'b0;
`ifdef PIPE_REGISTER_ZERO_IDLE_EN
            d <= '0;
`endif
        end else if (load) begin
            v <= up_valid;
            if (up_valid) begin
                d <= up_data;
            end
`ifdef PIPE_REGISTER_ZERO_IDLE_EN
            else begin
                d <= '0;
            end
`endif
        end
    end

endmodule

// File: rtl/pipe_register.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy level.
// Optional macro PIPE_REGISTER_ZERO_IDLE_EN zeroes the data of empty slices.
module pipe_register
    import pipe_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LVL_W = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LVL_W-1:0] level
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];
    logic             push;
    logic             pop;

    // Slice i may advance when the sink is ready or any slice downstream of it is empty.
    always_comb begin
        logic hole;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        hole = 1'b0;
        rdy  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = out_ready || hole;
            hole   = hole || !v[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        if (i == 0) begin : g_head
            pipe_reg_slice #(.WIDTH(WIDTH)) u_slice (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_valid (in_valid),
                .up_data  (in_data),
                .rdy      (rdy[i]),
                .v        (v[i]),
                .d        (d[i])
            );
        end else begin : g_body
            pipe_reg_slice #(.WIDTH(WIDTH)) u_slice (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_valid (v[i-1]),
                .up_data  (d[i-1]),
                .rdy      (rdy[i]),
                .v        (v[i]),
                .d        (d[i])
            );
        end
    end

    assign in_ready  = (!v[0] || rdy[0]) && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Internal shifts conserve the word count, so only boundary transfers move the level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

endmodule
